regfile_op_sequencer: RTL
=========================

// Module: regfile_op_sequencer
// PURPOSE
//  Sequences single-port register-file accesses to execute two-operand ALU commands (rd <= rs1 OP rs2 / imm).
//  Sits between a command source and the 8x8 register file (3-bit read/write selects, no write enable).
//  Owns the read select, write select and write data of the register file.
//  The register file has no write enable: on any non-write cycle this block writes the read register back to itself.
// PARAMETERS
//  DATA_W  8  datapath width; the register file width
//  ADDR_W  3  register select width (2**ADDR_W registers)
// PORTS
//  clk        in   1       single clock; all state on rising edge
//  reset      in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       block can accept a command; high only in IDLE
//  cmd_op     in   3       opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 LDI, 7 SHL
//  cmd_rd     in   ADDR_W  destination register
//  cmd_rs1    in   ADDR_W  source A
//  cmd_rs2    in   ADDR_W  source B (binary ops only)
//  cmd_imm    in   DATA_W  immediate (LDI only)
//  rf_read    out  ADDR_W  register file read select
//  rf_rdata   in   DATA_W  register file read data (combinational from rf_read)
//  rf_write   out  ADDR_W  register file write select
//  rf_wdata   out  DATA_W  register file write data
//  done       out  1       one-cycle pulse: command retired
//  result     out  DATA_W  value written to rd; held until next done
//  flag_c     out  1       carry (ADD), borrow (SUB), shifted-out MSB (SHL); 0 otherwise
//  flag_z     out  1       result == 0
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, opa/opb/result 0, done/flag_c/flag_z 0, latched cmd 0.
//  - FSM: IDLE -> RD_A -> RD_B -> WR -> IDLE.
//    IDLE: cmd_ready=1; cmd_valid=1 latches op/rd/rs1/rs2/imm. Next state is RD_A; LDI goes to WR.
//    RD_A: rf_read=rs1; opa<=rf_rdata. Next state is RD_B for binary ops, WR for MOV/SHL.
//    RD_B: rf_read=rs2; opb<=rf_rdata.
//    WR: rf_write=rd, rf_wdata=alu(op,opa,opb,imm); result/flags registered at this edge.
//  - done is registered: high the cycle after WR, coinciding with IDLE, so cmd_ready=1 in the same cycle.
//    A command can be accepted in the done cycle (back-to-back).
//  - Latency, accept edge to done high:
//    3 cycles for binary ops, 2 for MOV/SHL, 1 for LDI.
//  - Write-protect refresh: in every state except WR, rf_write=rf_read and rf_wdata=rf_rdata.
//    In IDLE, rf_read holds its last value (0 after reset).
//  - Arithmetic is mod 2**DATA_W. ADD: {c,r}=a+b. SUB: r=a-b, c=(a<b). SHL: r=a<<1, c=a[MSB].
//    MOV: r=a. LDI: r=imm. AND/OR/XOR: c=0.
//  - rd equal to rs1 or rs2 is legal: sources are captured before WR.
//  - cmd_* inputs are ignored outside IDLE. cmd_valid held high re-issues the command each time IDLE is reached.
//  - Reset mid-command: the command is dropped, no done pulse, no WR edge after reset.
// STRUCTURE
//  - Shared package regfile_ctrl_pkg: opcode localparams (OP_ADD..OP_SHL) and state encoding (S_IDLE, S_RD_A, S_RD_B, S_WR).
//  - One sub-module, seq_alu: combinational (op, a, b, imm) -> (r, c).
//  - FSM, operand latches and refresh muxing stay in this module.
// TESTING (bench instantiates this block plus the 8x8 register file)
//  1. Preload R1=0x0F, R2=0x01 via LDI; ADD rd=3,rs1=1,rs2=2.
//     -> done 3 cycles after accept, result=0x10, c=0, z=0, R3=0x10.
//  2. R1=0xFF, R2=0x01; ADD rd=4. -> result=0x00, c=1, z=1.
//     Then SUB rd=5 (rs1=2,rs2=1). -> 0x02, c=1.
//  3. R6=0x81; SHL rd=6,rs1=6. -> R6=0x02, c=1, 2-cycle latency.
//     All other registers unchanged (refresh check, read back all 8).
//  4. cmd_valid held high with 4 LDIs (imm 0x11..0x44 to R0..R3).
//     -> done every 2 cycles, no command lost or duplicated.
//  5. Assert reset in RD_B of an XOR to R7 (R7=0x5A).
//     -> no done, state IDLE, cmd_ready=1; R7 value follows register file reset only.
//  6. MOV rd=2,rs1=2 and AND rd=1,rs1=1,rs2=1 with R1=0xA5.
//     -> values unchanged, AND z=0, c=0.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared opcode and FSM-state definitions for the register-file op sequencer.
// Imported by the sequencer top and its ALU.
package regfile_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD_A = 2'd1,
    S_RD_B = 2'd2,
    S_WR   = 2'd3
  } state_t;

  // Binary ops (ADD..XOR) are the only ones that need a second register read.
  function automatic logic is_binary(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the op sequencer: (op, a, b, imm) -> (r, c).
// The carry output c is carry for ADD, borrow for SUB, and the shifted-out MSB for SHL.
module seq_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] r,
  output logic              c
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    r = '0;
    c = 1'b0;
    unique case (op)
      OP_ADD: begin
        r = sum[DATA_W-1:0];
        c = sum[DATA_W];
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_MOV: r = a;
      OP_LDI: r = imm;
      OP_SHL: begin
        r = {a[DATA_W-2:0], 1'b0};
        c = a[DATA_W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Drives a single-port, write-enable-less register file through read A / read B / write steps.
// On every non-write cycle, the register being read is written back to itself so that it is preserved.
module regfile_op_sequencer
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_read,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] rf_write,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_c,
  output logic              flag_z
);

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q, read_q;
  logic [DATA_W-1:0]   imm_q, opa_q, opb_q;
  logic [DATA_W-1:0]   alu_r;
  logic                alu_c;

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op_q),
    .a   (opa_q),
    .b   (opb_q),
    .imm (imm_q),
    .r   (alu_r),
    .c   (alu_c)
  );

  always_comb begin
    state_d   = state_q;
    rf_read   = read_q;
    cmd_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_op == OP_LDI) ? S_WR : S_RD_A;
      end
      S_RD_A: begin
        rf_read = rs1_q;
        state_d = is_binary(op_q) ? S_RD_B : S_WR;
      end
      S_RD_B: begin
        rf_read = rs2_q;
        state_d = S_WR;
      end
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outside WR, the selected register is refreshed with its own value.
  assign rf_write = (state_q == S_WR) ? rd_q  : rf_read;
  assign rf_wdata = (state_q == S_WR) ? alu_r : rf_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      read_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      result  <= '0;
      done    <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      state_q <= state_d;
      read_q  <= rf_read;
      done    <= (state_q == S_WR);
      if (state_q == S_IDLE && cmd_valid) begin
        op_q  <= cmd_op;
        rd_q  <= cmd_rd;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        imm_q <= cmd_imm;
      end
      if (state_q == S_RD_A) opa_q <= rf_rdata;
      if (state_q == S_RD_B) opb_q <= rf_rdata;
      if (state_q == S_WR) begin
        result <= alu_r;
        flag_c <= alu_c;
        flag_z <= (alu_r == '0);
      end
    end
  end

endmodule
